// File: rtl/mag_bin_sequencer.sv
// Walks one frame of FFT bins through the shared magnitude unit and streams results.
// Define MAG_PEAK_TRACK_EN to track the frame's peak magnitude and its bin index.
module mag_bin_sequencer #(
    parameter int N_BINS = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [2*DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0]   mag_rea,
    output logic [DATA_W-1:0]   mag_ima,
    input  logic [DATA_W-1:0]   mag_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W-1:0]   out_idx,
    output logic [DATA_W-1:0]   peak_mag,
    output logic [ADDR_W-1:0]   peak_idx
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        CAP,
        OUT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BINS - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic              go;
    logic              kill;
    logic              last;

    assign go   = (state == IDLE) && start && !abort;
    assign kill = (state != IDLE) && abort;
    assign last = (idx == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nx = RD;
                end
            end
            RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = idx;
                state_nx  = LAT;
            end
            LAT: state_nx = CAP;
            CAP: state_nx = OUT;
            OUT: begin
                if (out_ready) begin
                    state_nx = last ? DONE : RD;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // abort outranks both a handshake and any other transition
        if (kill) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            mag_rea   <= '0;
            mag_ima   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (kill) begin
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        idx <= '0;
                    end
                end
                LAT: begin
                    mag_rea <= mem_rd_data[2*DATA_W-1:DATA_W];
                    mag_ima <= mem_rd_data[DATA_W-1:0];
                end
                CAP: begin
                    out_data  <= mag_in;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!last) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MAG_PEAK_TRACK_EN
    // strict compare keeps the earliest bin on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (go) begin
            peak_mag <= '0;
            peak_idx <= '0;
        end else if (state == CAP && !abort && mag_in > peak_mag) begin
            peak_mag <= mag_in;
            peak_idx <= idx;
        end
    end
`else
    assign peak_mag = '0;
    assign peak_idx = '0;
`endif

endmodule

// File: tb/tb_mag_bin_sequencer.sv
// Directed and randomized frames for mag_bin_sequencer against a queue-based reference.
module tb_mag_bin_sequencer;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rd_data;
    logic [DW-1:0] mag_rea;
    logic [DW-1:0] mag_ima;
    logic [DW-1:0] mag_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] peak_mag;
    logic [AW-1:0] peak_idx;

    logic [31:0] ram [0:N-1];
    logic [31:0] rd_q;
    logic [21:0] got[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int reads;
    int dones;
    int first_rd;
    int done_cyc;

    mag_bin_sequencer #(.N_BINS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mag_rea(mag_rea), .mag_ima(mag_ima), .mag_in(mag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .peak_mag(peak_mag), .peak_idx(peak_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mag_of(input logic [31:0] w);
        int re;
        int im;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        if (re < 0) re = -re;
        if (im < 0) im = -im;
        return 16'(re + im);
    endfunction

    assign mag_in      = mag_of({mag_rea, mag_ima});
    assign mem_rd_data = rd_q;

    always @(posedge clk) begin
        if (mem_rd_en) rd_q <= ram[mem_addr[1:0]];
    end

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (!rst) begin
            if (mem_rd_en) begin
                reads++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready && !abort)
                got.push_back({out_idx, out_data});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        reads    = 0;
        dones    = 0;
        first_rd = -1;
        done_cyc = -1;
        got.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_bin_out(input int b);
        bit hit = 0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid && out_idx == AW'(b)) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_out", 64'(hit), 64'd1);
    endtask

    task automatic wait_rd(input int b);
        bit hit = 0;
        for (int i = 0; i < 200; i++) begin
            if (mem_rd_en && mem_addr == AW'(b)) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_rd", 64'(hit), 64'd1);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        logic [15:0] pk;
        int          pi;
        logic [15:0] m;
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("done_seen", 64'(done), 64'd1);
        pk = '0;
        pi = 0;
        for (int i = 0; i < N; i++) begin
            m = mag_of(ram[i]);
            if (m > pk) begin
                pk = m;
                pi = i;
            end
        end
`ifdef MAG_PEAK_TRACK_EN
        chk("peak_mag", 64'(peak_mag), 64'(pk));
        chk("peak_idx", 64'(peak_idx), 64'(pi));
`else
        chk("peak_mag_off", 64'(peak_mag), 64'd0);
        chk("peak_idx_off", 64'(peak_idx), 64'd0);
`endif
        out_ready = 1'b1;
    endtask

    task automatic check_frame(input int exp_lat);
        #2;
        chk("reads", 64'(reads), 64'(N));
        chk("dones", 64'(dones), 64'd1);
        chk("n_out", 64'(got.size()), 64'(N));
        for (int i = 0; i < got.size() && i < N; i++)
            chk("out", 64'(got[i]), 64'({6'(i), mag_of(ram[i])}));
        if (exp_lat > 0)
            chk("latency", 64'(done_cyc - first_rd + 1), 64'(exp_lat));
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_pulse_len", 64'(done), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        rd_q      = '0;
        ram[0] = {16'd3, 16'd0};
        ram[1] = {16'd0, 16'd5};
        ram[2] = {16'd7, 16'd0};
        ram[3] = {16'd0, 16'd2};
        clear_mon();
        repeat (3) @(negedge clk);
        chk("reset_state",
            {busy, done, mem_rd_en, mem_addr, mag_rea, mag_ima, out_valid, out_data, out_idx},
            64'd0);
        chk("reset_peak", 64'({peak_mag, peak_idx}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // nominal frame
        clear_mon();
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(100, 0);
        check_frame(4 * N + 1);

        // backpressure on bin 1 for 10 cycles
        clear_mon();
        pulse_start();
        wait_bin_out(1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'd5);
        end
        out_ready = 1'b1;
        wait_done(100, 0);
        check_frame(4 * N + 11);

        // restart while busy is ignored
        clear_mon();
        pulse_start();
        wait_rd(2);
        pulse_start();
        wait_done(100, 0);
        check_frame(4 * N + 1);
        repeat (10) @(negedge clk);
        chk("no_restart", 64'(busy), 64'd0);

        // start together with abort in idle
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'd0);

        // abort against a handshake in OUT of bin 1
        clear_mon();
        pulse_start();
        wait_bin_out(1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        #2;
        chk("abort_no_done", 64'(dones), 64'd0);
        chk("abort_n_out", 64'(got.size()), 64'd1);
        chk("abort_reads", 64'(reads), 64'd2);
        @(negedge clk);
        clear_mon();
        pulse_start();
        wait_done(100, 0);
        check_frame(4 * N + 1);

        // async reset in LAT of bin 2
        clear_mon();
        pulse_start();
        wait_rd(2);
        @(negedge clk);
        chk("pre_rst_data", 64'(out_data), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_lat",
            {busy, done, mem_rd_en, mem_addr, mag_rea, mag_ima, out_valid, out_data, out_idx},
            64'd0);
        chk("rst_mid_peak", 64'({peak_mag, peak_idx}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_done", 64'(dones), 64'd0);
        clear_mon();
        pulse_start();
        wait_done(100, 0);
        check_frame(4 * N + 1);

        // peak tie: magnitudes 4,9,9,1
        ram[0] = {16'd4, 16'd0};
        ram[1] = {16'd0, 16'd9};
        ram[2] = {16'hFFF7, 16'd0};
        ram[3] = {16'd1, 16'd0};
        clear_mon();
        pulse_start();
        wait_done(100, 0);
        check_frame(4 * N + 1);

        // random frames with random backpressure
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) ram[i] = $urandom;
            clear_mon();
            pulse_start();
            wait_done(600, 1);
            check_frame(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mag_bin_sequencer.md
Name: mag_bin_sequencer

Overview:
- Sequences a full frame of FFT output bins through the shared magnitude datapath, one bin at a time.
- Reads complex bins from the FFT result RAM, which has a 1-cycle read latency.
- Presents each bin's real/imag operands to the external combinational magnitude unit and registers its result.
- Streams the magnitudes to downstream logic over a valid/ready handshake, with start/busy/done control for the FFT top-level.

Parameters:
- N_BINS, 64, number of bins per frame; must be ≥2.
- ADDR_W, 6, RAM address width; must satisfy 2**ADDR_W ≥ N_BINS.
- DATA_W, 16, width of each real/imag component and of the magnitude.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame start; ignored while busy=1.
- abort  in  1  synchronous abort of the frame in progress.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse after the last bin is accepted downstream.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address (bin index).
- mem_rd_data  in  2*DATA_W  {re, im}, valid the cycle after mem_rd_en.
- mag_rea  out  DATA_W  real operand to the magnitude unit (registered).
- mag_ima  out  DATA_W  imag operand to the magnitude unit (registered).
- mag_in  in  DATA_W  combinational magnitude result from the unit.
- out_valid  out  1  output magnitude valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  bin magnitude.
- out_idx  out  ADDR_W  bin index of out_data.
- peak_mag  out  DATA_W  largest magnitude in the frame (optional feature).
- peak_idx  out  ADDR_W  bin index of peak_mag (optional feature).

Behaviour:
- Reset: every output, state register and internal counter goes to 0 and the FSM enters IDLE.
- States: IDLE, RD, LAT, CAP, OUT, DONE.
- IDLE:
  - busy=0.
  - start=1 → idx<=0, go to RD.
- RD:
  - mem_rd_en=1, mem_addr=idx (combinational from state).
  - Go to LAT.
- LAT:
  - mag_rea<=mem_rd_data[2*DATA_W-1:DATA_W], mag_ima<=mem_rd_data[DATA_W-1:0].
  - Go to CAP.
- CAP:
  - out_data<=mag_in, out_idx<=idx, out_valid<=1.
  - Go to OUT.
- OUT:
  - Hold out_valid, out_data and out_idx stable until out_ready=1.
  - On handshake: out_valid<=0.
  - If idx==N_BINS-1, go to DONE; else idx<=idx+1 and go to RD.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Go to IDLE.
- Timing:
  - Minimum of 4 cycles per bin (RD, LAT, CAP, OUT with out_ready=1).
  - Frame with out_ready held high: 4*N_BINS+1 cycles from the first RD cycle to the done pulse.
- mag_rea and mag_ima hold their values outside LAT, so the magnitude unit sees stable inputs in CAP.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; out_valid<=0.
  - No done pulse; operand registers retain their values.
  - abort takes priority over start and over an OUT handshake in the same cycle.
- start=1 while busy=1 is ignored; there is no queueing.
- start and abort both high in IDLE: start is ignored.
- Async rst mid-frame: immediate return to IDLE with all outputs 0; no done pulse.
- idx never exceeds N_BINS-1; no wrap-around occurs within a frame.

Optional Feature:
- Macro: MAG_PEAK_TRACK_EN.
- When defined:
  - peak_mag and peak_idx clear to 0 on an accepted start.
  - In CAP, if mag_in > peak_mag (strict), update both; the first occurrence wins ties.
  - Final values are valid from the done cycle onward and hold until the next accepted start.
- When undefined: peak_mag and peak_idx are tied to 0 and no comparator is synthesized.

Test Plan:
- N_BINS=4, RAM holds {re,im} = {3,0},{0,5},{7,0},{0,2}; magnitude model = |re|+|im|; out_ready held 1 → out_data 3,5,7,2 with out_idx 0..3; done 17 cycles after the first RD; busy drops the cycle after done.
- Same frame with out_ready low for 10 cycles on bin 1 → out_valid stays 1 and out_data holds 5 for all 10 cycles; no extra RAM reads; done is delayed by 10 cycles.
- start pulsed again during bin 2 → ignored; exactly 4 outputs and one done pulse.
- abort asserted in OUT of bin 1 with out_ready=1 in the same cycle → out_valid=0 and busy=0 next cycle; no done; the next start replays from idx 0.
- rst asserted asynchronously mid-LAT → all outputs 0 immediately; a subsequent start runs a full clean frame.
- MAG_PEAK_TRACK_EN with magnitudes 4,9,9,1 → peak_mag=9, peak_idx=1 at done; without the macro, both are 0 throughout.
